// File: rtl/mem_if.sv
// mem_if: request/response bundle between the core's request unit and mem_responder.
interface mem_if;
   logic        imemren;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        iready;
   logic        dmemren;
   logic        dmemwen;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [3:0]  dmembyteen;
   logic [31:0] dmemload;
   logic        dready;
   logic        busy;
   modport master (
      output imemren, imemaddr, dmemren, dmemwen, dmemaddr, dmemstore, dmembyteen,
      input  imemload, iready, dmemload, dready, busy
   );
   modport slave (
      input  imemren, imemaddr, dmemren, dmemwen, dmemaddr, dmemstore, dmembyteen,
      output imemload, iready, dmemload, dready, busy
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: arbitrated fetch/data responder over one word-addressed RAM with wait states.
module mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input logic  clk,
   input logic  nRST,
   mem_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t              r_state, w_next;
   logic [3:0]          r_cnt;
   logic                r_owner;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_store;
   logic [3:0]          r_be;
   logic [31:0]         r_iload;
   logic [31:0]         r_dload;
   logic [31:0]         r_mem [2**ADDR_W];
   logic                w_dreq;
   logic                w_accept;
   logic                w_owner;
   logic                w_wr;
   logic [31:0]         w_req_byte;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_unused;
   // In IDLE the live request feeds the RAM read so LATENCY=0 can answer on the accepting edge
   always_comb begin
      w_dreq     = bus.dmemren | bus.dmemwen;
      w_accept   = (r_state == IDLE) && (w_dreq || bus.imemren);
      w_req_byte = w_dreq ? bus.dmemaddr : bus.imemaddr;
      w_unused   = ^{w_req_byte[31:ADDR_W+2], w_req_byte[1:0]};
      w_owner    = (r_state == IDLE) ? w_dreq : r_owner;
      w_wr       = (r_state == IDLE) ? bus.dmemwen : r_wr;
      w_addr     = (r_state == IDLE) ? w_req_byte[ADDR_W+1:2] : r_addr;
      w_next     = (r_state == RESP) ? IDLE :
                   (r_state == WAIT) ? ((r_cnt == 4'd1) ? RESP : WAIT) :
                   !w_accept         ? IDLE :
                   (LATENCY == 0)    ? RESP : WAIT;
   end
   always_ff @(posedge clk or negedge nRST)
      if (!nRST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_owner <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_store <= '0;
         r_be    <= '0;
         r_iload <= '0;
         r_dload <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cnt   <= 4'(LATENCY);
            r_owner <= w_dreq;
            r_wr    <= bus.dmemwen;
            r_addr  <= w_addr;
            r_store <= bus.dmemstore;
            r_be    <= bus.dmembyteen;
         end else if (r_state == WAIT)
            r_cnt <= r_cnt - 4'd1;
         if (w_next == RESP && !w_owner)
            r_iload <= r_mem[w_addr];
         if (w_next == RESP && w_owner)
            r_dload <= w_wr ? '0 : r_mem[w_addr];
      end
   // Array is not reset; a reset aborts the write because r_state leaves RESP asynchronously
   always_ff @(posedge clk)
      if (r_state == RESP && r_owner && r_wr)
         for (int k = 0; k < 4; k++)
            if (r_be[k])
               r_mem[r_addr][8*k +: 8] <= r_store[8*k +: 8];
   assign bus.iready   = (r_state == RESP) && !r_owner;
   assign bus.dready   = (r_state == RESP) && r_owner;
   assign bus.busy     = (r_state != IDLE);
   assign bus.imemload = r_iload;
   assign bus.dmemload = r_dload;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LATENCY=2 (dut) and LATENCY=0 (dut0).
module tb_mem_responder;
   logic clk = 1'b0;
   logic nRST = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   mem_if bus ();
   mem_if bus0 ();
   mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (.clk(clk), .nRST(nRST), .bus(bus));
   mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .nRST(nRST), .bus(bus0));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic data_op(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int cycles, output logic [31:0] load,
                          output int busy_cycles);
      bus.dmemren = !wen;
      bus.dmemwen = wen;
      bus.dmemaddr = addr;
      bus.dmemstore = data;
      bus.dmembyteen = be;
      cycles = -1;
      busy_cycles = 0;
      load = 'x;
      for (int i = 1; i <= 20 && cycles < 0; i++) begin
         tick();
         busy_cycles += int'(bus.busy);
         if (bus.dready) begin
            cycles = i;
            load = bus.dmemload;
         end
      end
      bus.dmemren = 1'b0;
      bus.dmemwen = 1'b0;
      tick();
      busy_cycles += int'(bus.busy);
   endtask
   task automatic test_reset();
      #12;
      n_total++; if ({bus.iready, bus.dready, bus.busy} !== 3'b000) $display("FAIL rst_flags: got %b, want 000", {bus.iready, bus.dready, bus.busy}); else n_pass++;
      n_total++; if (bus.dmemload !== 32'h0) $display("FAIL rst_dmemload: got %h, want 00000000", bus.dmemload); else n_pass++;
      n_total++; if (bus.imemload !== 32'h0) $display("FAIL rst_imemload: got %h, want 00000000", bus.imemload); else n_pass++;
      n_total++; if ({bus0.iready, bus0.dready, bus0.busy} !== 3'b000) $display("FAIL rst0_flags: got %b, want 000", {bus0.iready, bus0.dready, bus0.busy}); else n_pass++;
      n_total++; if (bus0.imemload !== 32'h0) $display("FAIL rst0_imemload: got %h, want 00000000", bus0.imemload); else n_pass++;
      nRST = 1'b1;
      tick();
   endtask
   task automatic test_write_read();
      int c, b;
      logic [31:0] ld;
      data_op(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, c, ld, b);
      n_total++; if (c !== 3) $display("FAIL wr_latency: got %0d, want 3", c); else n_pass++;
      n_total++; if (b !== 3) $display("FAIL wr_busy_cycles: got %0d, want 3", b); else n_pass++;
      n_total++; if (bus.dready !== 1'b0) $display("FAIL wr_dready_pulse: got %b, want 0", bus.dready); else n_pass++;
      data_op(1'b0, 32'h40, 32'h0, 4'h0, c, ld, b);
      n_total++; if (c !== 3) $display("FAIL rd_latency: got %0d, want 3", c); else n_pass++;
      n_total++; if (ld !== 32'hDEADBEEF) $display("FAIL rd_data: got %h, want deadbeef", ld); else n_pass++;
   endtask
   task automatic test_partial_store();
      int c, b;
      logic [31:0] ld;
      data_op(1'b1, 32'h40, 32'h11223344, 4'b0101, c, ld, b);
      n_total++; if (ld !== 32'h0) $display("FAIL wr_dmemload_zero: got %h, want 00000000", ld); else n_pass++;
      data_op(1'b0, 32'h40, 32'h0, 4'h0, c, ld, b);
      n_total++; if (ld !== 32'hDE22BE44) $display("FAIL partial_40: got %h, want de22be44", ld); else n_pass++;
      data_op(1'b0, 32'h43, 32'h0, 4'h0, c, ld, b);
      n_total++; if (ld !== 32'hDE22BE44) $display("FAIL partial_43: got %h, want de22be44", ld); else n_pass++;
      data_op(1'b0, 32'h1040, 32'h0, 4'h0, c, ld, b);
      n_total++; if (ld !== 32'hDE22BE44) $display("FAIL wrap_1040: got %h, want de22be44", ld); else n_pass++;
   endtask
   task automatic test_back_to_back();
      int c, b, dcyc, icyc;
      logic overlap;
      logic [31:0] ld, dld, ild;
      data_op(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, c, ld, b);
      dcyc = -1;
      icyc = -1;
      overlap = 1'b0;
      dld = 'x;
      ild = 'x;
      bus.imemren = 1'b1;
      bus.imemaddr = 32'h0;
      bus.dmemren = 1'b1;
      bus.dmemaddr = 32'h40;
      for (int i = 1; i <= 20 && icyc < 0; i++) begin
         tick();
         if (bus.iready && bus.dready) overlap = 1'b1;
         if (bus.dready) begin
            dcyc = i;
            dld = bus.dmemload;
            bus.dmemren = 1'b0;
         end
         if (bus.iready) begin
            icyc = i;
            ild = bus.imemload;
            bus.imemren = 1'b0;
         end
      end
      bus.dmemren = 1'b0;
      bus.imemren = 1'b0;
      tick();
      n_total++; if (dcyc !== 3) $display("FAIL arb_dready_cycle: got %0d, want 3", dcyc); else n_pass++;
      n_total++; if (icyc !== 7) $display("FAIL arb_iready_cycle: got %0d, want 7", icyc); else n_pass++;
      n_total++; if (overlap !== 1'b0) $display("FAIL arb_overlap: got %b, want 0", overlap); else n_pass++;
      n_total++; if (dld !== 32'hDE22BE44) $display("FAIL arb_dmemload: got %h, want de22be44", dld); else n_pass++;
      n_total++; if (ild !== 32'hCAFEF00D) $display("FAIL arb_imemload: got %h, want cafef00d", ild); else n_pass++;
   endtask
   task automatic test_drop();
      int c, b, cyc;
      logic [31:0] ld;
      data_op(1'b1, 32'h104, 32'h0, 4'hF, c, ld, b);
      cyc = -1;
      bus.dmemwen = 1'b1;
      bus.dmemaddr = 32'h100;
      bus.dmemstore = 32'hAAAA5555;
      bus.dmembyteen = 4'hF;
      tick();
      bus.dmemwen = 1'b0;
      bus.dmemaddr = 32'h104;
      bus.dmemstore = 32'h12345678;
      for (int i = 2; i <= 20 && cyc < 0; i++) begin
         tick();
         if (bus.dready) cyc = i;
      end
      tick();
      n_total++; if (cyc !== 3) $display("FAIL drop_dready_cycle: got %0d, want 3", cyc); else n_pass++;
      data_op(1'b0, 32'h100, 32'h0, 4'h0, c, ld, b);
      n_total++; if (ld !== 32'hAAAA5555) $display("FAIL drop_latched: got %h, want aaaa5555", ld); else n_pass++;
      data_op(1'b0, 32'h104, 32'h0, 4'h0, c, ld, b);
      n_total++; if (ld !== 32'h0) $display("FAIL drop_new_addr: got %h, want 00000000", ld); else n_pass++;
   endtask
   task automatic test_reset_mid();
      int c, b;
      logic seen;
      logic [31:0] ld;
      data_op(1'b1, 32'h80, 32'h0BADCAFE, 4'hF, c, ld, b);
      data_op(1'b0, 32'h80, 32'h0, 4'h0, c, ld, b);
      bus.dmemwen = 1'b1;
      bus.dmemaddr = 32'h80;
      bus.dmemstore = 32'hFFFFFFFF;
      bus.dmembyteen = 4'hF;
      tick();
      n_total++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %b, want 1", bus.busy); else n_pass++;
      #2 nRST = 1'b0;
      #1;
      n_total++; if ({bus.busy, bus.dready, bus.iready} !== 3'b000) $display("FAIL mid_flags: got %b, want 000", {bus.busy, bus.dready, bus.iready}); else n_pass++;
      n_total++; if (bus.dmemload !== 32'h0) $display("FAIL mid_dmemload: got %h, want 00000000", bus.dmemload); else n_pass++;
      n_total++; if (bus.imemload !== 32'h0) $display("FAIL mid_imemload: got %h, want 00000000", bus.imemload); else n_pass++;
      bus.dmemwen = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.dready) seen = 1'b1;
      end
      nRST = 1'b1;
      tick();
      if (bus.dready) seen = 1'b1;
      n_total++; if (seen !== 1'b0) $display("FAIL mid_no_dready: got %b, want 0", seen); else n_pass++;
      data_op(1'b0, 32'h80, 32'h0, 4'h0, c, ld, b);
      n_total++; if (ld !== 32'h0BADCAFE) $display("FAIL mid_no_write: got %h, want 0badcafe", ld); else n_pass++;
   endtask
   task automatic test_latency0();
      int cyc, k;
      for (int w = 0; w < 4; w++) begin
         bus0.dmemwen = 1'b1;
         bus0.dmemaddr = 32'(4 * w);
         bus0.dmemstore = 32'h1000 + 32'(w);
         bus0.dmembyteen = 4'hF;
         cyc = -1;
         for (int i = 1; i <= 10 && cyc < 0; i++) begin
            tick();
            if (bus0.dready) cyc = i;
         end
         bus0.dmemwen = 1'b0;
         tick();
         n_total++; if (cyc !== 1) $display("FAIL lat0_wr_latency[%0d]: got %0d, want 1", w, cyc); else n_pass++;
      end
      k = 0;
      bus0.imemren = 1'b1;
      bus0.imemaddr = 32'h0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_total++; if (bus0.iready !== 1'(i % 2)) $display("FAIL lat0_iready_c%0d: got %b, want %b", i, bus0.iready, 1'(i % 2)); else n_pass++;
         if (bus0.iready) begin
            n_total++; if (bus0.imemload !== 32'h1000 + 32'(k)) $display("FAIL lat0_imemload[%0d]: got %h, want %h", k, bus0.imemload, 32'h1000 + 32'(k)); else n_pass++;
            k++;
            bus0.imemaddr = bus0.imemaddr + 32'd4;
         end
      end
      bus0.imemren = 1'b0;
      tick();
      n_total++; if (k !== 4) $display("FAIL lat0_fetch_count: got %0d, want 4", k); else n_pass++;
   endtask
   initial begin
      bus.imemren = 1'b0;
      bus.imemaddr = '0;
      bus.dmemren = 1'b0;
      bus.dmemwen = 1'b0;
      bus.dmemaddr = '0;
      bus.dmemstore = '0;
      bus.dmembyteen = '0;
      bus0.imemren = 1'b0;
      bus0.imemaddr = '0;
      bus0.dmemren = 1'b0;
      bus0.dmemwen = 1'b0;
      bus0.dmemaddr = '0;
      bus0.dmemstore = '0;
      bus0.dmembyteen = '0;
      test_reset();
      test_write_read();
      test_partial_store();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_latency0();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
